// File: rtl/char_serial_tx.sv
// ---------------------------------------------------------------------------
// char_serial_tx
//
// Purpose:
//   Takes 7-bit ASCII codes from the character coder, buffers them in a
//   small FIFO and sends each one as an asynchronous serial frame:
//   start bit (0), 7 data bits LSB first, optional even-parity bit, and a
//   stop bit (1). Frames go out back-to-back while the FIFO has data. The
//   result can drive a UART-style line or a scope pin.
//
// Parameters:
//   CLKS_PER_BIT  CLK cycles per serial bit-time (>= 1)
//   FIFO_DEPTH    character buffer entries (power of 2, >= 2)
//   CNT_W         width of the completed-frame counter
//
// Ports:
//   CLK       in   1      system clock, all state changes on posedge
//   RST_N     in   1      asynchronous active-low reset
//   CHAR_IN   in   7      ASCII code, bit 6 = MSB
//   IN_VALID  in   1      CHAR_IN valid this cycle
//   IN_READY  out  1      FIFO can accept (combinational, = !full)
//   TXD       out  1      registered serial line, idle high
//   BUSY      out  1      FSM active or FIFO holding characters
//   OVERFLOW  out  1      sticky, set when IN_VALID arrives while not ready
//   CHAR_CNT  out  CNT_W  completed frames, wraps modulo 2**CNT_W
//
// Build option:
//   PARITY_TX_EN  when defined, an even-parity bit (XOR of the 7 data bits)
//                 is sent between the last data bit and the stop bit.
// ---------------------------------------------------------------------------
module char_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       CHAR_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             TXD,
    output logic             BUSY,
    output logic             OVERFLOW,
    output logic [CNT_W-1:0] CHAR_CNT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef PARITY_TX_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------------------------------------------------------
    // Character FIFO
    // ---------------------------------------------------------------
    logic [6:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [6:0]       fifo_head;
    logic             push;
    logic             fsm_pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    // IN_READY depends only on the registered count, so a pop on the same
    // edge never lets a new character slip into a full buffer.
    assign IN_READY = !fifo_full;
    assign push     = IN_VALID && !fifo_full;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= CHAR_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fsm_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, fsm_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Sticky overflow flag; the rejected character is simply dropped.
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVERFLOW <= 1'b0;
        end else if (IN_VALID && fifo_full) begin
            OVERFLOW <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------
    state_t           state;
    state_t           state_n;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [6:0]       shift;
    logic [6:0]       shift_n;
    logic             txd_n;
    logic             tick;
    logic             frame_done;
`ifdef PARITY_TX_EN
    logic             par_q;
    logic             par_n;
`endif

    assign tick = (timer == TMR_MAX);
    assign BUSY = (state != IDLE) || !fifo_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TXD      <= 1'b1;
            CHAR_CNT <= '0;
`ifdef PARITY_TX_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            TXD     <= txd_n;
            if (frame_done) begin
                CHAR_CNT <= CHAR_CNT + 1'b1;
            end
`ifdef PARITY_TX_EN
            par_q   <= par_n;
`endif
        end
    end

    // TXD is registered from the *next* state so the line changes on the
    // same edge as the state does; a load at edge n+1 drives the start bit
    // from that edge. The shift register is consumed as bits go out, so the
    // parity bit is captured whole at load time.
    always_comb begin
        state_n    = state;
        timer_n    = tick ? '0 : timer + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        fsm_pop    = 1'b0;
        frame_done = 1'b0;
        txd_n      = 1'b1;
`ifdef PARITY_TX_EN
        par_n      = par_q;
`endif

        case (state)
            IDLE: begin
                timer_n = '0;
                if (!fifo_empty) begin
                    fsm_pop = 1'b1;
                    shift_n = fifo_head;
                    state_n = START;
`ifdef PARITY_TX_EN
                    par_n   = ^fifo_head;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift[6:1]};
                    if (bit_idx == 3'd6) begin
`ifdef PARITY_TX_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef PARITY_TX_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    // Chain straight into the next frame when data waits.
                    if (!fifo_empty) begin
                        fsm_pop = 1'b1;
                        shift_n = fifo_head;
                        state_n = START;
`ifdef PARITY_TX_EN
                        par_n   = ^fifo_head;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            IDLE:    txd_n = 1'b1;
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
`ifdef PARITY_TX_EN
            PARITY:  txd_n = par_n;
`endif
            STOP:    txd_n = 1'b1;
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_char_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_char_serial_tx
//
// Self-checking bench for char_serial_tx with CLKS_PER_BIT=2, FIFO_DEPTH=4.
// A second instance with CNT_W=2 shares all inputs and is used to check
// frame-counter wrap-around. Expected frame bit patterns are hand-written
// in the vector table; burst frames use a small frame model.
// Honours PARITY_TX_EN for frame length and parity bit.
// ---------------------------------------------------------------------------
module tb_char_serial_tx;

    localparam int CPB = 2;
`ifdef PARITY_TX_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       CLK;
    logic       RST_N;
    logic [6:0] CHAR_IN;
    logic       IN_VALID;
    logic       IN_READY;
    logic       TXD;
    logic       BUSY;
    logic       OVERFLOW;
    logic [7:0] CHAR_CNT;

    logic       ready2;
    logic       txd2;
    logic       busy2;
    logic       ovf2;
    logic [1:0] cnt2;

    int compared   = 0;
    int mismatched = 0;
    int exp_cnt    = 0;

    typedef struct {
        logic [6:0] ch;
        logic [8:0] frame9;   // {stop, data[6:0], start}, bit 0 sent first
        logic       par;
    } vec_t;

    vec_t vecs[6];

    char_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CHAR_IN  (CHAR_IN),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .TXD      (TXD),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW),
        .CHAR_CNT (CHAR_CNT)
    );

    char_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(2)) dut2 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CHAR_IN  (CHAR_IN),
        .IN_VALID (IN_VALID),
        .IN_READY (ready2),
        .TXD      (txd2),
        .BUSY     (busy2),
        .OVERFLOW (ovf2),
        .CHAR_CNT (cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [6:0] ch, input logic valid);
        CHAR_IN  = ch;
        IN_VALID = valid;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Model of a frame as a bit vector, bit 0 transmitted first.
    function automatic logic [9:0] modelFrame(input logic [6:0] ch);
`ifdef PARITY_TX_EN
        return {1'b1, ^ch, ch, 1'b0};
`else
        return {2'b01, ch, 1'b0};
`endif
    endfunction

    // Per-cycle line level: each bit held for CPB cycles.
    function automatic logic [19:0] expandWave(input logic [9:0] frm);
        logic [19:0] w;
        w = '0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            w[c] = frm[c / CPB];
        end
        return w;
    endfunction

    // Push one character from IDLE and follow its frame to completion.
    // Called #1 after a posedge; returns #1 after the counting edge.
    task automatic sendFrame(input logic [6:0] ch, input logic [9:0] frm,
                             input string tag);
        logic [19:0] wave;
        wave = '0;
        applyStimulus(ch, 1'b1);
        checkOutput({tag, " ready"}, 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        applyStimulus(~ch, 1'b0);
        checkOutput({tag, " txd before load"}, 32'(TXD), 32'd1);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(posedge CLK); #1;
            wave[c] = TXD;
            if (c == FRAME_CYC / 2) begin
                checkOutput({tag, " busy mid"}, 32'(BUSY), 32'd1);
            end
        end
        checkOutput({tag, " wave"}, 32'(wave), 32'(expandWave(frm)));
        checkOutput({tag, " cnt before stop end"}, 32'(CHAR_CNT), 32'(exp_cnt % 256));
        @(posedge CLK); #1;
        exp_cnt++;
        checkOutput({tag, " cnt"}, 32'(CHAR_CNT), 32'(exp_cnt % 256));
        checkOutput({tag, " busy after"}, 32'(BUSY), 32'd0);
        checkOutput({tag, " txd idle"}, 32'(TXD), 32'd1);
    endtask

    initial begin
        logic        txd_all;
        logic        busy_any;
        logic [99:0] wave3;
        logic [19:0] slice;
        logic [9:0]  frm;
        logic [1:0]  wrap_exp[5];

        vecs[0] = '{ch: 7'h4E, frame9: 9'b110011100, par: 1'b0};
        vecs[1] = '{ch: 7'h43, frame9: 9'b110000110, par: 1'b1};
        vecs[2] = '{ch: 7'h00, frame9: 9'b100000000, par: 1'b0};
        vecs[3] = '{ch: 7'h7F, frame9: 9'b111111110, par: 1'b1};
        vecs[4] = '{ch: 7'h55, frame9: 9'b110101010, par: 1'b0};
        vecs[5] = '{ch: 7'h2A, frame9: 9'b101010100, par: 1'b1};
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        // Reset state
        RST_N = 1'b0;
        applyStimulus(7'h00, 1'b0);
        #12;
        checkOutput("reset txd", 32'(TXD), 32'd1);
        checkOutput("reset ready", 32'(IN_READY), 32'd1);
        checkOutput("reset busy", 32'(BUSY), 32'd0);
        checkOutput("reset overflow", 32'(OVERFLOW), 32'd0);
        checkOutput("reset cnt", 32'(CHAR_CNT), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        txd_all = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            txd_all &= TXD;
        end
        checkOutput("idle line after release", 32'(txd_all), 32'd1);

        // Single frames from the vector table
        $display("[TB] single-frame vectors");
        for (int i = 0; i < 6; i++) begin
`ifdef PARITY_TX_EN
            frm = {1'b1, vecs[i].par, vecs[i].frame9[7:0]};
`else
            frm = {1'b0, vecs[i].frame9};
`endif
            sendFrame(vecs[i].ch, frm, $sformatf("vec%0d", i));
        end

        // Burst of six: five accepted, sixth overflows and is dropped
        $display("[TB] burst with overflow");
        checkOutput("overflow before burst", 32'(OVERFLOW), 32'd0);
        wave3 = '0;
        applyStimulus(7'h41, 1'b1);
        checkOutput("burst ready 1", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        for (int c = 0; c < 5 * FRAME_CYC; c++) begin
            if (c < 5) begin
                applyStimulus(7'(7'h42 + c), 1'b1);
                checkOutput($sformatf("burst ready %0d", c + 2), 32'(IN_READY),
                            (c < 4) ? 32'd1 : 32'd0);
            end else begin
                applyStimulus(7'h00, 1'b0);
            end
            @(posedge CLK); #1;
            wave3[c] = TXD;
        end
        for (int f = 0; f < 5; f++) begin
            slice = '0;
            for (int c = 0; c < FRAME_CYC; c++) begin
                slice[c] = wave3[f * FRAME_CYC + c];
            end
            checkOutput($sformatf("burst frame %0d", f), 32'(slice),
                        32'(expandWave(modelFrame(7'(7'h41 + f)))));
        end
        @(posedge CLK); #1;
        exp_cnt += 5;
        checkOutput("burst cnt", 32'(CHAR_CNT), 32'(exp_cnt % 256));
        checkOutput("burst busy after", 32'(BUSY), 32'd0);
        checkOutput("burst overflow sticky", 32'(OVERFLOW), 32'd1);
        checkOutput("burst ready after", 32'(IN_READY), 32'd1);

        // Reset during DATA bit 3 with two characters queued
        $display("[TB] reset mid-frame");
        applyStimulus(7'h30, 1'b1);
        @(posedge CLK); #1;
        applyStimulus(7'h31, 1'b1);
        @(posedge CLK); #1;
        applyStimulus(7'h32, 1'b1);
        @(posedge CLK); #1;
        applyStimulus(7'h00, 1'b0);
        repeat (7) @(posedge CLK);
        #1;
        checkOutput("data bit3 before reset", 32'(TXD), 32'd0);
        RST_N = 1'b0;
        #1;
        checkOutput("async reset txd", 32'(TXD), 32'd1);
        checkOutput("async reset busy", 32'(BUSY), 32'd0);
        checkOutput("async reset overflow", 32'(OVERFLOW), 32'd0);
        checkOutput("async reset cnt", 32'(CHAR_CNT), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        exp_cnt  = 0;
        txd_all  = 1'b1;
        busy_any = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            txd_all  &= TXD;
            busy_any |= BUSY;
        end
        checkOutput("no frames after reset", 32'(txd_all), 32'd1);
        checkOutput("idle after reset", 32'(busy_any), 32'd0);
        checkOutput("cnt after reset", 32'(CHAR_CNT), 32'd0);

        // Narrow counter wrap on the CNT_W=2 instance
        $display("[TB] counter wrap");
        for (int i = 0; i < 5; i++) begin
            sendFrame(vecs[i].ch, modelFrame(vecs[i].ch), $sformatf("wrap%0d", i));
            checkOutput($sformatf("wrap cnt2 %0d", i), 32'(cnt2), 32'(wrap_exp[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
